// File: rtl/seq_bin_divider_pkg.sv
// Shared constants and state encoding for the sequential binary divider.
package seq_bin_divider_pkg;

    // Default divisor/quotient/remainder width; the dividend is twice as wide.
    localparam int unsigned DEFAULT_BIT_W = 7;

    // Controller states: waiting for a request, or iterating one quotient bit per clock.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        DIVIDE = 1'b1
    } state_e;

endpackage : seq_bin_divider_pkg

// File: rtl/seq_bin_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_bin_divider_if
    import seq_bin_divider_pkg::*;
#(
    parameter int unsigned BIT_W = DEFAULT_BIT_W
);

    logic                   start;
    logic [2*BIT_W-1:0]     I_D;
    logic [BIT_W-1:0]       I_B;
    logic                   ready;
    logic                   overflow;
    logic [BIT_W-1:0]       quotient;
    logic [BIT_W-1:0]       remainder;

    modport master (
        output start, I_D, I_B,
        input  ready, overflow, quotient, remainder
    );

    modport slave (
        input  start, I_D, I_B,
        output ready, overflow, quotient, remainder
    );

endinterface : seq_bin_divider_if

// File: rtl/seq_bin_divider_div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract B, set the new quotient bit.
module div_step
    import seq_bin_divider_pkg::*;
#(
    parameter int unsigned BIT_W = DEFAULT_BIT_W
) (
    input  logic [BIT_W:0]   a,
    input  logic [BIT_W-1:0] q,
    input  logic [BIT_W-1:0] b,
    output logic [BIT_W:0]   a_next_c,
    output logic [BIT_W-1:0] q_next_c
);

    logic [2*BIT_W:0] aq_shift;
    logic [BIT_W:0]   a_shift;
    logic             ge;

    // A is one bit wider than B so the bit shifted out of Q's neighbour still takes part in the compare.
    always_comb begin
        aq_shift = {a, q} << 1;
        a_shift  = aq_shift[2*BIT_W:BIT_W];
        ge       = (a_shift >= {1'b0, b});
        a_next_c = ge ? (a_shift - {1'b0, b}) : a_shift;
        q_next_c = aq_shift[BIT_W-1:0] | BIT_W'(ge);
    end

endmodule : div_step

// File: rtl/seq_bin_divider.sv
// Sequential restoring divider: 2*BIT_W-bit dividend by BIT_W-bit divisor, one quotient bit per clock.
module seq_bin_divider
    import seq_bin_divider_pkg::*;
#(
    parameter int unsigned BIT_W = DEFAULT_BIT_W
) (
    input  logic             clk,
    input  logic             reset,
    seq_bin_divider_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(BIT_W + 1);

    state_e             state_q, state_d;
    logic [BIT_W:0]     a_q, a_d;
    logic [BIT_W-1:0]   q_q, q_d;
    logic [BIT_W-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               overflow_q, overflow_d;
    logic [BIT_W-1:0]   quotient_q, quotient_d;
    logic [BIT_W-1:0]   remainder_q, remainder_d;

    logic [BIT_W:0]     a_next_c;
    logic [BIT_W-1:0]   q_next_c;

    div_step #(
        .BIT_W    (BIT_W)
    ) u_div_step (
        .a        (a_q),
        .q        (q_q),
        .b        (b_q),
        .a_next_c (a_next_c),
        .q_next_c (q_next_c)
    );

    // Next-state and result logic; operands are latched at capture so input changes mid-run are harmless.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        overflow_d  = overflow_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.I_D[2*BIT_W-1:BIT_W] >= bus.I_B) begin
                        // Quotient cannot fit in BIT_W bits (or divisor is zero): reject without iterating.
                        overflow_d  = 1'b1;
                        quotient_d  = '0;
                        remainder_d = '0;
                        ready_d     = 1'b1;
                    end else begin
                        overflow_d  = 1'b0;
                        a_d         = {1'b0, bus.I_D[2*BIT_W-1:BIT_W]};
                        q_d         = bus.I_D[BIT_W-1:0];
                        b_d         = bus.I_B;
                        cnt_d       = CNT_W'(BIT_W);
                        ready_d     = 1'b0;
                        state_d     = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                a_d   = a_next_c;
                q_d   = q_next_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = IDLE;
                    ready_d     = 1'b1;
                    quotient_d  = q_next_c;
                    remainder_d = a_next_c[BIT_W-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset discards any in-flight division.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            overflow_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.overflow  = overflow_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule : seq_bin_divider

// File: tb/tb_seq_bin_divider.sv
// Bench for seq_bin_divider: directed corner cases plus a random sweep, checked against an arithmetic model.
module tb_seq_bin_divider;

    localparam int unsigned BW   = 7;
    localparam int unsigned QLIM = 1 << BW;

    logic clk;
    logic reset;

    seq_bin_divider_if #(.BIT_W(BW)) bus ();

    seq_bin_divider #(
        .BIT_W (BW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec;
    int n_err;
    bit chk_en;

    // Behavioural model: busy for BW cycles after an accepted request, results from / and %.
    bit m_busy;
    int m_left;
    bit m_done;
    int m_ovf;
    int m_q;
    int m_r;
    int cap_d;
    int cap_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update on each rising edge using the inputs that were stable before it.
    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_left = 0;
            m_ovf  = 0;
            m_q    = 0;
            m_r    = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                if (int'(bus.I_B) == 0 || (int'(bus.I_D) / int'(bus.I_B)) >= int'(QLIM)) begin
                    m_ovf = 1;
                    m_q   = 0;
                    m_r   = 0;
                end else begin
                    m_busy = 1'b1;
                    m_left = BW;
                    m_ovf  = 0;
                    cap_d  = int'(bus.I_D);
                    cap_b  = int'(bus.I_B);
                end
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_q    = cap_d / cap_b;
                m_r    = cap_d % cap_b;
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(bus.ready), 32'(!m_busy));
            if (!m_busy) begin
                chk("overflow", 32'(bus.overflow), 32'(m_ovf));
                chk("quotient", 32'(bus.quotient), 32'(m_q));
                chk("remainder", 32'(bus.remainder), 32'(m_r));
            end
            if (m_done) begin
                chk("identity", 32'(int'(bus.quotient) * cap_b + int'(bus.remainder)), 32'(cap_d));
                chk("rem_lt_b", 32'(int'(bus.remainder) < cap_b), 32'd1);
            end
        end
    end

    // One request pulse, then wait (bounded) for ready; lat counts edges after capture.
    task automatic run_div(input logic [2*BW-1:0] d, input logic [BW-1:0] b, output int lat);
        bus.I_D   = d;
        bus.I_B   = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.ready && lat < 40) begin
            tick();
            lat++;
        end
        chk("ready_timeout", 32'(bus.ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int b;
        int d;

        n_vec     = 0;
        n_err     = 0;
        chk_en    = 1'b0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.I_D   = '0;
        bus.I_B   = '0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state.
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_q", 32'(bus.quotient), 32'd0);
        chk("rst_r", 32'(bus.remainder), 32'd0);

        // 10000 / 100.
        run_div(14'd10000, 7'd100, lat);
        chk("lat_10000_100", 32'(lat), 32'd7);
        chk("q_10000_100", 32'(bus.quotient), 32'd100);
        chk("r_10000_100", 32'(bus.remainder), 32'd0);
        chk("ovf_10000_100", 32'(bus.overflow), 32'd0);

        // Largest quotient that fits.
        run_div(14'd12799, 7'd100, lat);
        chk("q_12799_100", 32'(bus.quotient), 32'd127);
        chk("r_12799_100", 32'(bus.remainder), 32'd99);
        chk("ovf_12799_100", 32'(bus.overflow), 32'd0);

        // Results hold in IDLE.
        tick();
        tick();
        chk("hold_q", 32'(bus.quotient), 32'd127);
        chk("hold_r", 32'(bus.remainder), 32'd99);

        // Divisor zero and quotient too large: rejected, ready straight back.
        run_div(14'd5000, 7'd0, lat);
        chk("lat_div0", 32'(lat), 32'd0);
        chk("ovf_div0", 32'(bus.overflow), 32'd1);
        chk("q_div0", 32'(bus.quotient), 32'd0);
        chk("r_div0", 32'(bus.remainder), 32'd0);
        run_div(14'd16383, 7'd1, lat);
        chk("lat_big", 32'(lat), 32'd0);
        chk("ovf_big", 32'(bus.overflow), 32'd1);
        chk("q_big", 32'(bus.quotient), 32'd0);

        // Start held high: completion, one valid cycle, then immediate restart.
        bus.I_D   = 14'd729;
        bus.I_B   = 7'd9;
        bus.start = 1'b1;
        tick();
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        lat = 0;
        while (!bus.ready && lat < 40) begin
            tick();
            lat++;
        end
        chk("lat_729_a", 32'(lat), 32'd7);
        chk("q_729_a", 32'(bus.quotient), 32'd81);
        chk("r_729_a", 32'(bus.remainder), 32'd0);
        tick();
        chk("restart_busy", 32'(bus.ready), 32'd0);
        lat = 0;
        while (!bus.ready && lat < 40) begin
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk("lat_729_b", 32'(lat), 32'd7);
        chk("q_729_b", 32'(bus.quotient), 32'd81);
        chk("r_729_b", 32'(bus.remainder), 32'd0);

        // Reset three cycles into a division, then a clean run.
        bus.I_D   = 14'd10000;
        bus.I_B   = 7'd99;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_ovf", 32'(bus.overflow), 32'd0);
        chk("midrst_q", 32'(bus.quotient), 32'd0);
        chk("midrst_r", 32'(bus.remainder), 32'd0);
        run_div(14'd10000, 7'd99, lat);
        chk("q_10000_99", 32'(bus.quotient), 32'd101);
        chk("r_10000_99", 32'(bus.remainder), 32'd1);

        // Reset wins over start on the same edge.
        bus.I_D   = 14'd10000;
        bus.I_B   = 7'd100;
        bus.start = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_prio_ready", 32'(bus.ready), 32'd1);
        chk("rst_prio_q", 32'(bus.quotient), 32'd0);

        // Random sweep with operand and start noise while dividing.
        for (int n = 0; n < 80; n++) begin
            b = int'($urandom_range(127, 1));
            if ($urandom_range(7, 0) == 0)
                d = (int'($urandom_range(127, b)) << BW) | int'($urandom_range(127, 0));
            else
                d = (int'($urandom_range(b - 1, 0)) << BW) | int'($urandom_range(127, 0));
            bus.I_D   = 14'(d);
            bus.I_B   = 7'(b);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            lat = 0;
            while (!bus.ready && lat < 40) begin
                bus.I_D   = 14'($urandom);
                bus.I_B   = 7'($urandom);
                bus.start = 1'($urandom_range(1, 0));
                tick();
                lat++;
            end
            bus.start = 1'b0;
            chk("rand_ready", 32'(bus.ready), 32'd1);
            tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_bin_divider

// File: doc/seq_bin_divider.md
SEQ_BIN_DIVIDER -- requirements
Module: seq_bin_divider

Interface
REQ-001 Parameter: bit, default 7, divisor/quotient/remainder width; dividend width is 2*bit.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request; sampled only while in IDLE.
REQ-005 I_D  input  2*bit  dividend, unsigned.
REQ-006 I_B  input  bit  divisor, unsigned.
REQ-007 ready  output  1  high in IDLE; results valid whenever high.
REQ-008 overflow  output  1  high when last division was rejected (quotient would not fit bit bits, or divisor zero).
REQ-009 quotient  output  bit  unsigned quotient of last completed division.
REQ-010 remainder  output  bit  unsigned remainder of last completed division.

Function
REQ-011 The block SHALL implement restoring shift-subtract division, one quotient bit per clock, with states IDLE, DIVIDE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL capture I_D and I_B, clear overflow, drop ready, and load an iteration counter with bit.
REQ-013 At that same capture edge, if I_D[2*bit-1:bit] >= I_B (includes I_B=0), the block SHALL instead set overflow=1, set quotient=0 and remainder=0, and stay in IDLE with ready=1.
REQ-014 Otherwise it SHALL enter DIVIDE; each DIVIDE cycle: shift {A,Q} left by one, if shifted A >= B then A <= A-B and Q[0] <= 1, else Q[0] <= 0; decrement counter.
REQ-015 Partial remainder A SHALL be bit+1 bits wide so the shifted-out MSB participates in the compare; no other carry is lost.
REQ-016 After the bit-th DIVIDE cycle the block SHALL return to IDLE with quotient=Q, remainder=A[bit-1:0], ready=1; total latency from capture edge to ready high is exactly bit rising edges (bit+1 edges including capture).
REQ-017 start SHALL be ignored while in DIVIDE; I_D/I_B changes during DIVIDE SHALL NOT affect the result.
REQ-018 start held continuously high SHALL restart a new division on the first edge ready is seen high in IDLE (results from the previous run remain valid for that one cycle).
REQ-019 quotient, remainder and overflow SHALL hold their values in IDLE until the next capture.
REQ-020 Results SHALL satisfy I_D = quotient*I_B + remainder and remainder < I_B whenever overflow=0.

Reset
REQ-021 reset=1 at a rising edge SHALL force IDLE, ready=1, overflow=0, quotient=0, remainder=0, counter=0, from any state including mid-DIVIDE (in-flight division discarded).
REQ-022 reset SHALL take priority over start on the same edge.

Structure
REQ-023 A shared package SHALL hold the IDLE/DIVIDE state encoding and the default bit width constant; counter width is $clog2(bit+1) derived locally.
REQ-024 One sub-module, div_step, SHALL implement the combinational shift/compare/subtract of one iteration; FSM, counter and registers stay in seq_bin_divider.

Verification
REQ-025 bit=7, I_D=10000, I_B=100, start pulse -> ready low for 7 cycles, then quotient=100, remainder=0, overflow=0.
REQ-026 bit=7, I_D=12799, I_B=100 -> quotient=127, remainder=99, overflow=0 (max quotient boundary).
REQ-027 bit=7, I_D=729, I_B=9, start held high throughout -> quotient=81, remainder=0, then immediate restart with same result.
REQ-028 bit=7, I_B=0, any I_D; and I_D=16383, I_B=1 -> overflow=1, quotient=0, remainder=0, ready high the cycle after capture.
REQ-029 bit=7, I_D=10000, I_B=99, reset asserted 3 cycles into DIVIDE -> next edge ready=1, all outputs 0; following start gives quotient=101, remainder=1.
REQ-030 Random sweep, bit=7, non-overflow operands, I_D/I_B toggled during DIVIDE -> REQ-020 holds for captured operands on every run.
